// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if -- instruction-memory handshake bundle for if_stage.
//
// Signals:
//   imem_req    fetch stage -> memory : request valid
//   imem_addr   fetch stage -> memory : 16-bit word address
//   imem_ready  memory -> fetch stage : request accepted this cycle
//   imem_rdata  memory -> fetch stage : instruction word, valid when accepted
//
// Modports:
//   master  used by if_stage (drives req/addr)
//   slave   used by the memory side (drives ready/rdata)
// ----------------------------------------------------------------------------
interface if_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with a one-entry skid register.
//
// Fetches 16-bit instructions from a word-addressed instruction memory and
// presents them as registered IF/ID fields. A FETCH/DRAIN/HOLD FSM handles
// downstream stall (instruction parked in the skid register while in HOLD)
// and branch redirects (an unaccepted outstanding request is drained and its
// data dropped). branch_taken has priority over stall in every state.
//
// Parameters:
//   RESET_PC        first word address fetched after reset
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   stall           ID stage cannot accept a new instruction
//   branch_taken    redirect request
//   branch_target   redirect word address
//   imem            instruction-memory handshake (if_stage_if.master)
//   instr_valid     IF/ID holds a valid instruction
//   opcode/rs/rt/rd/funct/signalToExtend   decoded IF/ID fields
//   pc_out          address of the IF/ID instruction
//   pc_plus1        pc_out + 1
//   fetch_count     accepted-instruction counter
//
// Optional feature:
//   IF_FETCH_COUNT_EN  when defined, fetch_count counts every instruction
//                      written to IF/ID with instr_valid=1 (skid transfers
//                      included); otherwise fetch_count is tied to zero.
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_target,
    if_stage_if.master        imem,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [2:0]        rs,
    output logic [2:0]        rt,
    output logic [2:0]        rd,
    output logic [1:0]        funct,
    output logic [5:0]        signalToExtend,
    output logic [15:0]       pc_out,
    output logic [15:0]       pc_plus1,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;

    // Low during reset and until the first edge after it; gates imem_req.
    logic        r_active;

    logic [15:0] r_pc,          w_pc_nxt;
    logic [15:0] r_drain_addr,  w_drain_addr_nxt;
    logic [15:0] r_skid_instr,  w_skid_instr_nxt;
    logic [15:0] r_skid_pc,     w_skid_pc_nxt;
    logic [15:0] r_instr,       w_instr_nxt;
    logic [15:0] r_pc_out,      w_pc_out_nxt;
    logic [15:0] r_pc_plus1,    w_pc_plus1_nxt;
    logic        r_valid,       w_valid_nxt;

    logic        w_req;
    logic        w_accept;

    assign w_req          = r_active && (r_state != S_HOLD);
    assign w_accept       = w_req && imem.imem_ready;

    // DRAIN keeps presenting the address whose request is still outstanding.
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_drain_addr_nxt = r_drain_addr;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
        w_instr_nxt      = r_instr;
        w_pc_out_nxt     = r_pc_out;
        w_pc_plus1_nxt   = r_pc_plus1;
        w_valid_nxt      = r_valid;

        case (r_state)
            S_FETCH: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                    // Outstanding but unaccepted request must be drained.
                    if (w_req && !imem.imem_ready) begin
                        w_state_nxt      = S_DRAIN;
                        w_drain_addr_nxt = r_pc;
                    end
                end else if (w_accept) begin
                    w_pc_nxt = r_pc + 16'd1;
                    if (stall) begin
                        w_skid_instr_nxt = imem.imem_rdata;
                        w_skid_pc_nxt    = r_pc;
                        w_state_nxt      = S_HOLD;
                    end else begin
                        w_instr_nxt    = imem.imem_rdata;
                        w_pc_out_nxt   = r_pc;
                        w_pc_plus1_nxt = r_pc + 16'd1;
                        w_valid_nxt    = 1'b1;
                    end
                end else if (!stall) begin
                    w_valid_nxt = 1'b0;
                end
            end

            S_DRAIN: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                end
                if (w_accept) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_HOLD: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_instr_nxt    = r_skid_instr;
                    w_pc_out_nxt   = r_skid_pc;
                    w_pc_plus1_nxt = r_skid_pc + 16'd1;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_active     <= 1'b0;
            r_pc         <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_instr      <= '0;
            r_pc_out     <= '0;
            r_pc_plus1   <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_active     <= 1'b1;
            r_pc         <= w_pc_nxt;
            r_drain_addr <= w_drain_addr_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_instr      <= w_instr_nxt;
            r_pc_out     <= w_pc_out_nxt;
            r_pc_plus1   <= w_pc_plus1_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    assign instr_valid    = r_valid;
    assign opcode         = r_instr[15:12];
    assign rs             = r_instr[11:9];
    assign rt             = r_instr[8:6];
    assign rd             = r_instr[5:3];
    assign funct          = r_instr[1:0];
    assign signalToExtend = r_instr[5:0];
    assign pc_out         = r_pc_out;
    assign pc_plus1       = r_pc_plus1;

`ifdef IF_FETCH_COUNT_EN
    logic [15:0] r_fetch_count;
    logic        w_load_rdata;
    logic        w_load_skid;

    assign w_load_rdata = (r_state == S_FETCH) && !branch_taken && w_accept && !stall;
    assign w_load_skid  = (r_state == S_HOLD)  && !branch_taken && !stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_count <= '0;
        end else if (w_load_rdata || w_load_skid) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = '0;
`endif

endmodule
